mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX result valid
- ex_ready  out  1  stage can accept an EX result
- ex_result  in  XLEN  ALU result: load/store byte address, or writeback value
- ex_store_data  in  XLEN  rs2 value for stores
- ex_rd  in  5  destination register
- ex_reg_we  in  1  register write requested
- ex_mem_op  in  mem_op_t  memory operation
- dmem_req  out  1  bus request
- dmem_we  out  1  store
- dmem_addr  out  XLEN  word-aligned address, bits [1:0] = 0
- dmem_be  out  4  byte enables
- dmem_wdata  out  XLEN  lane-aligned store data
- dmem_ack  in  1  bus done; rdata valid this cycle
- dmem_rdata  in  XLEN  load word
- wb_valid  out  1  one-cycle writeback pulse
- wb_rd  out  5  writeback register
- wb_we  out  1  writeback enable
- wb_data  out  XLEN  writeback value
- misalign  out  1  one-cycle pulse with wb_valid on a misaligned access

Function
REQ-003 SHALL implement a state machine with states IDLE, ACCESS.
REQ-004 SHALL drive ex_ready = 1 in IDLE only; a transfer occurs when ex_valid && ex_ready.
REQ-005 SHALL complete a MEM_NONE transfer in cycle N with wb_valid = 1 at N+1, wb_data = ex_result, wb_we = ex_reg_we, wb_rd = ex_rd, and stay in IDLE.
REQ-006 SHALL treat word access with addr[1:0] != 0, or halfword access with addr[0] = 1, as misaligned.
REQ-007 SHALL complete a misaligned transfer at N+1 with misalign = 1, wb_valid = 1, wb_we = 0, and no bus request.
REQ-008 SHALL, for an aligned load or store accepted at N, enter ACCESS and assert dmem_req from N+1.
REQ-009 SHALL hold dmem_req, dmem_we, dmem_addr, dmem_be, and dmem_wdata constant in ACCESS until dmem_ack.
REQ-010 SHALL, on dmem_ack in cycle M, return to IDLE and assert wb_valid at M+1; the next EX transfer can then occur at M+1.
REQ-011 SHALL drive byte enables as follows:
- SB: 1 << addr[1:0]
- SH: 4'b0011 << addr[1:0]
- SW: 4'b1111
REQ-012 SHALL replicate store data to every lane: byte x4, halfword x2.
REQ-013 SHALL extract the addressed byte or halfword from dmem_rdata.
REQ-014 SHALL sign-extend LB/LH, zero-extend LBU/LHU, and pass LW unchanged.
REQ-015 SHALL, for stores, assert wb_valid with wb_we = 0.
REQ-016 SHALL ignore dmem_ack in IDLE.
REQ-017 SHALL keep wb_valid low except as specified above.

Reset
REQ-018 SHALL, on rst_n low, asynchronously force:
- state IDLE
- dmem_req, dmem_we, wb_valid, wb_we, misalign = 0
- dmem_addr, dmem_be, dmem_wdata, wb_rd, wb_data = 0
REQ-019 SHALL, on reset mid-ACCESS, abandon the transaction, produce no writeback, and ignore a late ack.
REQ-020 SHALL hold ex_ready = 0 while rst_n is low and drive ex_ready = 1 in the first cycle after release.

Structure
REQ-021 SHALL take mem_op_t from shared package mem_pkg, alongside alu_pkg. Encodings: MEM_NONE, LB, LH, LW, LBU, LHU, SB, SH, SW.
REQ-022 SHALL also place in mem_pkg an is_load/is_store helper and the byte-enable constants.
REQ-023 SHALL contain one sub-module, load_align: combinational extraction and extension per REQ-013/014.

Verification
REQ-024 SHALL cover MEM_NONE, ex_result = 32'h0000_1234, rd = 5, reg_we = 1 -> next cycle wb_valid = 1, wb_data = 32'h0000_1234, wb_rd = 5, no dmem_req.
REQ-025 SHALL cover LB at 32'h103, ack after 3 wait cycles, rdata = 32'h80FF_FFFF:
- dmem_addr = 32'h100 and dmem_be = 4'b1000, held for 4 cycles
- wb_data = 32'hFFFF_FF80 one cycle after ack
REQ-026 SHALL cover LHU at 32'h202, rdata = 32'h8001_0000 -> wb_data = 32'h0000_8001.
REQ-027 SHALL cover SH at 32'h302, data 32'hABCD_1234:
- dmem_be = 4'b1100, dmem_wdata = 32'h1234_1234, dmem_we = 1
- wb_valid with wb_we = 0
REQ-028 SHALL cover LW at 32'h401 -> misalign = 1 and wb_valid = 1 next cycle, wb_we = 0, dmem_req never asserted.
REQ-029 SHALL cover rst_n low during ACCESS, then ack after release -> no wb_valid, state IDLE, ex_ready = 1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-stage types: operation encodings, byte-enable constants and
// small classification helpers used by the MEM stage and its load aligner.
package mem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    LB       = 4'd1,
    LH       = 4'd2,
    LW       = 4'd3,
    LBU      = 4'd4,
    LHU      = 4'd5,
    SB       = 4'd6,
    SH       = 4'd7,
    SW       = 4'd8
  } mem_op_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic is_load(mem_op_t op);
    return op inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic logic is_store(mem_op_t op);
    return op inside {SB, SH, SW};
  endfunction

  function automatic logic is_misaligned(mem_op_t op, logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    case (op)
      LH, LHU, SH: mis = offset[0];
      LW, SW:      mis = (offset != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte and halfword enables slide up to the addressed lane.
  function automatic logic [3:0] byte_enable(mem_op_t op, logic [1:0] offset);
    logic [3:0] be;
    be = 4'b0000;
    case (op)
      LB, LBU, SB: be = BE_BYTE << offset;
      LH, LHU, SH: be = BE_HALF << offset;
      LW, SW:      be = BE_WORD;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/halfword out of a loaded word and extends it
// to the full datapath width according to the load flavour.
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  mem_op_t           op,
  input  logic [1:0]        offset,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = rdata[{offset, 3'b000} +: 8];
    half_val = rdata[{offset[1], 4'b0000} +: 16];
    case (op)
      LB:      data = {{(XLEN-8){byte_val[7]}}, byte_val};
      LBU:     data = {{(XLEN-8){1'b0}}, byte_val};
      LH:      data = {{(XLEN-16){half_val[15]}}, half_val};
      LHU:     data = {{(XLEN-16){1'b0}}, half_val};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: accepts one EX result at a time, runs at most one data
// bus transaction for it, and emits a single-cycle writeback pulse.
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_we,
  input  mem_op_t           ex_mem_op,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_we,
  output logic [XLEN-1:0]   wb_data,
  output logic              misalign
);

  mem_state_t      state;
  mem_op_t         acc_op;
  logic [1:0]      acc_offset;
  logic [4:0]      acc_rd;
  logic            acc_we;
  logic [1:0]      ex_offset;
  logic [XLEN-1:0] store_lanes;
  logic [XLEN-1:0] load_data;

  assign ex_offset = ex_result[1:0];

  // Gating with rst_n keeps the stage from advertising readiness during reset.
  assign ex_ready = rst_n && (state == IDLE);

  always_comb begin
    case (ex_mem_op)
      SB:      store_lanes = {(XLEN/8){ex_store_data[7:0]}};
      SH:      store_lanes = {(XLEN/16){ex_store_data[15:0]}};
      default: store_lanes = ex_store_data;
    endcase
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .op     (acc_op),
    .offset (acc_offset),
    .rdata  (dmem_rdata),
    .data   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= 4'b0000;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= '0;
      misalign   <= 1'b0;
      acc_op     <= MEM_NONE;
      acc_offset <= 2'b00;
      acc_rd     <= 5'd0;
      acc_we     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid && ex_ready) begin
            wb_rd <= ex_rd;
            if (ex_mem_op == MEM_NONE) begin
              wb_valid <= 1'b1;
              wb_we    <= ex_reg_we;
              wb_data  <= ex_result;
            end else if (is_misaligned(ex_mem_op, ex_offset)) begin
              wb_valid <= 1'b1;
              wb_we    <= 1'b0;
              wb_data  <= ex_result;
              misalign <= 1'b1;
            end else begin
              state      <= ACCESS;
              dmem_req   <= 1'b1;
              dmem_we    <= is_store(ex_mem_op);
              dmem_addr  <= {ex_result[XLEN-1:2], 2'b00};
              dmem_be    <= byte_enable(ex_mem_op, ex_offset);
              dmem_wdata <= store_lanes;
              acc_op     <= ex_mem_op;
              acc_offset <= ex_offset;
              acc_rd     <= ex_rd;
              acc_we     <= ex_reg_we && is_load(ex_mem_op);
            end
          end
        end
        ACCESS: begin
          // Bus outputs stay frozen until the acknowledge arrives.
          if (dmem_ack) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= acc_rd;
            wb_we    <= acc_we;
            wb_data  <= is_load(acc_op) ? load_data : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage: stimulus pushes expected writebacks,
// a negedge monitor pops and compares each wb_valid pulse.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_we;
  mem_op_t     ex_mem_op;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        misalign;

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic        mis;
    logic        chk;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  wb_exp_t item;
  int checks = 0;
  int errors = 0;

  mem_stage #(.XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_result     (ex_result),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_reg_we     (ex_reg_we),
    .ex_mem_op     (ex_mem_op),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_we         (wb_we),
    .wb_data       (wb_data),
    .misalign      (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, want finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  // Monitor: every writeback pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_wb: got wb_valid=1 rd=%0d, want no writeback", wb_rd);
      end else begin
        item = exp_q.pop_front();
        checkOutput("wb_rd", 32'(wb_rd), 32'(item.rd));
        checkOutput("wb_we", 32'(wb_we), 32'(item.we));
        checkOutput("misalign", 32'(misalign), 32'(item.mis));
        if (item.chk) checkOutput("wb_data", wb_data, item.data);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the writeback pulse.
  task automatic applyStimulus(input string tag, input mem_op_t op,
                               input logic [31:0] result, input logic [31:0] sdata,
                               input logic [4:0] rd, input logic reg_we,
                               input logic bus, input int waits,
                               input logic [31:0] rdata, input logic [31:0] exp_addr,
                               input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                               input logic exp_wbwe, input logic exp_chk,
                               input logic [31:0] exp_wbdata, input logic exp_mis);
    int   guard;
    logic st;
    st = (op == SB) || (op == SH) || (op == SW);
    ex_valid      = 1'b1;
    ex_mem_op     = op;
    ex_result     = result;
    ex_store_data = sdata;
    ex_rd         = rd;
    ex_reg_we     = reg_we;
    exp_q.push_back('{rd: rd, we: exp_wbwe, mis: exp_mis, chk: exp_chk, data: exp_wbdata});
    guard = 0;
    while (!ex_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, "_ex_ready"}, 32'(ex_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0;
    checkOutput({tag, "_req"}, 32'(dmem_req), 32'(bus));
    if (bus) begin
      checkOutput({tag, "_addr"}, dmem_addr, exp_addr);
      checkOutput({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
      checkOutput({tag, "_we"}, 32'(dmem_we), 32'(st));
      if (st) checkOutput({tag, "_wdata"}, dmem_wdata, exp_wdata);
      for (int w = 0; w < waits; w++) begin
        @(negedge clk);
        checkOutput({tag, "_req_hold"}, 32'(dmem_req), 32'd1);
        checkOutput({tag, "_addr_hold"}, dmem_addr, exp_addr);
        checkOutput({tag, "_be_hold"}, 32'(dmem_be), 32'(exp_be));
      end
      dmem_ack   = 1'b1;
      dmem_rdata = rdata;
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h5A5A_5A5A;
      checkOutput({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
      checkOutput({tag, "_req_done"}, 32'(dmem_req), 32'd0);
      checkOutput({tag, "_ready_again"}, 32'(ex_ready), 32'd1);
    end else begin
      checkOutput({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
    end
  endtask

  initial begin
    rst_n         = 1'b1;
    ex_valid      = 1'b0;
    ex_result     = '0;
    ex_store_data = '0;
    ex_rd         = '0;
    ex_reg_we     = 1'b0;
    ex_mem_op     = MEM_NONE;
    dmem_ack      = 1'b0;
    dmem_rdata    = '0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_ex_ready", 32'(ex_ready), 32'd0);
    checkOutput("rst_req", 32'(dmem_req), 32'd0);
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_be", 32'(dmem_be), 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("rel_ex_ready", 32'(ex_ready), 32'd1);
    @(negedge clk);

    applyStimulus("none", MEM_NONE, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 0, 32'h0,
                  32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0000_1234, 1'b0);
    applyStimulus("lb", LB, 32'h0000_0103, 32'h0, 5'd6, 1'b1, 1'b1, 3, 32'h80FF_FFFF,
                  32'h0000_0100, 4'b1000, 32'h0, 1'b1, 1'b1, 32'hFFFF_FF80, 1'b0);
    applyStimulus("lhu", LHU, 32'h0000_0202, 32'h0, 5'd7, 1'b1, 1'b1, 0, 32'h8001_0000,
                  32'h0000_0200, 4'b1100, 32'h0, 1'b1, 1'b1, 32'h0000_8001, 1'b0);
    applyStimulus("sh", SH, 32'h0000_0302, 32'hABCD_1234, 5'd8, 1'b1, 1'b1, 1, 32'h0,
                  32'h0000_0300, 4'b1100, 32'h1234_1234, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("lw_mis", LW, 32'h0000_0401, 32'h0, 5'd10, 1'b1, 1'b0, 0, 32'h0,
                  32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus("sb", SB, 32'h0000_0001, 32'h0000_0055, 5'd0, 1'b0, 1'b1, 2, 32'h0,
                  32'h0000_0000, 4'b0010, 32'h5555_5555, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("lh", LH, 32'h0000_0006, 32'h0, 5'd11, 1'b1, 1'b1, 1, 32'hF00D_8123,
                  32'h0000_0004, 4'b1100, 32'h0, 1'b1, 1'b1, 32'hFFFF_F00D, 1'b0);
    applyStimulus("lbu", LBU, 32'h0000_0002, 32'h0, 5'd12, 1'b1, 1'b1, 0, 32'h00AB_0000,
                  32'h0000_0000, 4'b0100, 32'h0, 1'b1, 1'b1, 32'h0000_00AB, 1'b0);
    applyStimulus("sw", SW, 32'h0000_000C, 32'hDEAD_BEEF, 5'd3, 1'b0, 1'b1, 0, 32'h0,
                  32'h0000_000C, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("lh_mis", LH, 32'h0000_0003, 32'h0, 5'd13, 1'b1, 1'b0, 0, 32'h0,
                  32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus("sh_mis", SH, 32'h0000_0001, 32'h1111_2222, 5'd2, 1'b0, 1'b0, 0, 32'h0,
                  32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus("lw", LW, 32'h0000_0010, 32'h0, 5'd14, 1'b1, 1'b1, 2, 32'h1234_5678,
                  32'h0000_0010, 4'b1111, 32'h0, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
    applyStimulus("none_nowe", MEM_NONE, 32'hCAFE_F00D, 32'h0, 5'd0, 1'b0, 1'b0, 0, 32'h0,
                  32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
    applyStimulus("lb_pos", LB, 32'h0000_0100, 32'h0, 5'd15, 1'b1, 1'b1, 0, 32'h0000_007F,
                  32'h0000_0100, 4'b0001, 32'h0, 1'b1, 1'b1, 32'h0000_007F, 1'b0);

    // Reset in the middle of a bus access: no writeback, late ack ignored.
    ex_valid  = 1'b1;
    ex_mem_op = LW;
    ex_result = 32'h0000_0500;
    ex_rd     = 5'd9;
    ex_reg_we = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0;
    checkOutput("abort_req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_req_rst", 32'(dmem_req), 32'd0);
    checkOutput("abort_ready_rst", 32'(ex_ready), 32'd0);
    checkOutput("abort_addr_rst", dmem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("abort_ready_rel", 32'(ex_ready), 32'd1);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1111_1111;
    @(negedge clk);
    dmem_ack = 1'b0;
    checkOutput("late_ack_wb", 32'(wb_valid), 32'd0);
    checkOutput("late_ack_req", 32'(dmem_req), 32'd0);
    checkOutput("late_ack_ready", 32'(ex_ready), 32'd1);
    repeat (2) begin
      @(negedge clk);
      checkOutput("late_ack_quiet", 32'(wb_valid), 32'd0);
    end

    applyStimulus("after_rst", MEM_NONE, 32'h0000_0042, 32'h0, 5'd1, 1'b1, 1'b0, 0, 32'h0,
                  32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0000_0042, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
